alarm_slot_editor: RTL and testbench

//  Multi-slot mm:ss alarm-time editor for the alarm-set mode: holds NUM_SLOTS alarm times, each 0..MAX_TIME-1 s.

---
 rtl/alarm_slot_editor.sv | 186 ++++++++++++++++++
 tb/tb_alarm_slot_editor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_slot_editor.sv
// Multi-slot mm:ss alarm editor: digit-wise button editing with hold-to-repeat,
// CENTER short press for next slot / long press to clear, blink mask for the display.
module alarm_slot_editor #(
    parameter int NUM_SLOTS    = 4,
    parameter int TW           = 12,
    parameter int MAX_TIME     = 3600,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int CLEAR_HOLD   = 1000,
    parameter int BLINK_HALF   = 500,
    localparam int AW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                    CLOCK_1ms,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic [4:0]              BTN,
    output logic [NUM_SLOTS*TW-1:0] TIME_ALL,
    output logic [AW-1:0]           ACTIVE_SLOT,
    output logic [TW-1:0]           DISP_TIME,
    output logic [3:0]              EDIT_DIGIT,
    output logic [3:0]              BLANK_MASK,
    output logic                    CHANGED
);
    // state    | meaning
    // R_IDLE   | no UP/DOWN repeat in progress
    // R_DELAY  | UP/DOWN held, waiting REPEAT_DELAY before auto-repeat
    // R_REPEAT | auto-repeat, one step every REPEAT_RATE
    // C_IDLE   | no CENTER press in progress
    // C_HOLD   | CENTER held, timing short press vs. clear
    // C_WAIT   | slot cleared, waiting for CENTER release
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} r_state_t;
    typedef enum logic [1:0] {C_IDLE, C_HOLD, C_WAIT} c_state_t;

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = $clog2(RMAX + 1);
    localparam int CCW  = $clog2(CLEAR_HOLD + 1);
    localparam int BCW  = $clog2(BLINK_HALF + 1);
    localparam logic [TW:0] MAX_W = (TW+1)'(MAX_TIME);

    logic [TW-1:0]  slot_t [NUM_SLOTS];
    logic [AW-1:0]  act_slot;
    logic [4:0]     btn_s1, btn_s2, btn_q;
    logic           enable_q, wr_q, phase;
    logic [BCW-1:0] blink_cnt;
    r_state_t       r_state;
    logic           r_dir;
    logic [RCW-1:0] r_cnt;
    c_state_t       c_state;
    logic [CCW-1:0] c_cnt;

    logic [4:0]  rise;
    logic        act, en_rise, any_ev, ev_left, ev_right, ev_up, ev_down, ev_center;
    logic        held_dir, both_ud;
    logic [TW:0] cur_t, w, sum;
    logic [TW-1:0] t_up, t_dn;

    // BTN bits: 4 DOWN, 3 RIGHT, 2 LEFT, 1 UP, 0 CENTER
    assign rise      = btn_s2 & ~btn_q;
    assign en_rise   = ENABLE & ~enable_q;
    assign act       = ENABLE & enable_q;
    assign any_ev    = act & (|rise);
    assign ev_left   = act & rise[2];
    assign ev_right  = act & rise[3] & ~rise[2];
    assign ev_up     = act & rise[1] & ~(|rise[3:2]);
    assign ev_down   = act & rise[4] & ~(|rise[3:1]);
    assign ev_center = act & rise[0] & ~(|rise[4:1]);
    assign held_dir  = r_dir ? btn_s2[4] : btn_s2[1];
    assign both_ud   = btn_s2[4] & btn_s2[1];

    always_comb begin
        cur_t = {1'b0, slot_t[act_slot]};
        if (EDIT_DIGIT[3])      w = (TW+1)'(600);
        else if (EDIT_DIGIT[2]) w = (TW+1)'(60);
        else if (EDIT_DIGIT[1]) w = (TW+1)'(10);
        else                    w = (TW+1)'(1);
        sum  = cur_t + w;
        t_up = TW'((sum >= MAX_W) ? sum - MAX_W : sum);
        t_dn = TW'((cur_t >= w) ? cur_t - w : cur_t + MAX_W - w);
    end

    always_comb begin
        TIME_ALL = '0;
        for (int k = 0; k < NUM_SLOTS; k++) TIME_ALL[k*TW +: TW] = slot_t[k];
    end

    assign ACTIVE_SLOT = act_slot;
    assign BLANK_MASK  = (ENABLE && phase) ? EDIT_DIGIT : 4'b0000;

    always_ff @(posedge CLOCK_1ms or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < NUM_SLOTS; k++) slot_t[k] <= '0;
            act_slot   <= '0;
            DISP_TIME  <= '0;
            EDIT_DIGIT <= 4'b1000;
            CHANGED    <= 1'b0;
            wr_q       <= 1'b0;
            // all-ones so a button held through reset is not seen as a new press
            btn_s1     <= '1;
            btn_s2     <= '1;
            btn_q      <= '1;
            enable_q   <= 1'b0;
            phase      <= 1'b0;
            blink_cnt  <= BCW'(BLINK_HALF - 1);
            r_state    <= R_IDLE;
            r_dir      <= 1'b0;
            r_cnt      <= '0;
            c_state    <= C_IDLE;
            c_cnt      <= '0;
        end else begin
            btn_s1    <= BTN;
            btn_s2    <= btn_s1;
            btn_q     <= btn_s2;
            enable_q  <= ENABLE;
            wr_q      <= 1'b0;
            CHANGED   <= wr_q;
            DISP_TIME <= slot_t[act_slot];
            if (!ENABLE) begin
                r_state   <= R_IDLE;
                c_state   <= C_IDLE;
                phase     <= 1'b0;
                blink_cnt <= BCW'(BLINK_HALF - 1);
            end else if (en_rise) begin
                EDIT_DIGIT <= 4'b1000;
                r_state    <= R_IDLE;
                c_state    <= C_IDLE;
                phase      <= 1'b0;
                blink_cnt  <= BCW'(BLINK_HALF - 1);
            end else begin
                if (any_ev) begin
                    phase     <= 1'b0;
                    blink_cnt <= BCW'(BLINK_HALF - 1);
                end else if (blink_cnt == '0) begin
                    phase     <= ~phase;
                    blink_cnt <= BCW'(BLINK_HALF - 1);
                end else begin
                    blink_cnt <= blink_cnt - 1'b1;
                end

                if (ev_left)  EDIT_DIGIT <= {EDIT_DIGIT[2:0], EDIT_DIGIT[3]};
                if (ev_right) EDIT_DIGIT <= {EDIT_DIGIT[0], EDIT_DIGIT[3:1]};

                if (ev_up || ev_down) begin
                    slot_t[act_slot] <= ev_down ? t_dn : t_up;
                    wr_q    <= 1'b1;
                    r_dir   <= ev_down;
                    r_state <= R_DELAY;
                    r_cnt   <= RCW'(REPEAT_DELAY - 1);
                end else if (any_ev) begin
                    r_state <= R_IDLE;
                end else if (r_state != R_IDLE) begin
                    if (!held_dir || both_ud) begin
                        r_state <= R_IDLE;
                    end else if (r_cnt == '0) begin
                        slot_t[act_slot] <= r_dir ? t_dn : t_up;
                        wr_q    <= 1'b1;
                        r_state <= R_REPEAT;
                        r_cnt   <= RCW'(REPEAT_RATE - 1);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                case (c_state)
                    C_IDLE: if (ev_center) begin
                        c_state <= C_HOLD;
                        c_cnt   <= CCW'(CLEAR_HOLD - 1);
                    end
                    C_HOLD: begin
                        if (!btn_s2[0]) begin
                            act_slot   <= (act_slot == AW'(NUM_SLOTS - 1)) ? '0 : act_slot + 1'b1;
                            EDIT_DIGIT <= 4'b1000;
                            c_state    <= C_IDLE;
                        end else if (c_cnt == '0) begin
                            slot_t[act_slot] <= '0;
                            wr_q    <= 1'b1;
                            c_state <= C_WAIT;
                        end else begin
                            c_cnt <= c_cnt - 1'b1;
                        end
                    end
                    default: if (!btn_s2[0]) c_state <= C_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alarm_slot_editor.sv
// Bench for alarm_slot_editor: vector table, hand-timed sequences and random taps vs. a model.
module tb_alarm_slot_editor;
    localparam int NS = 4, TW = 12, MAXT = 3600;

    logic          clk = 1'b0;
    logic          rst, en;
    logic [4:0]    btn;
    logic [NS*TW-1:0] time_all;
    logic [1:0]    active_slot;
    logic [TW-1:0] disp_time;
    logic [3:0]    edit_digit, blank_mask;
    logic          changed;

    alarm_slot_editor dut (
        .CLOCK_1ms(clk), .RESET(rst), .ENABLE(en), .BTN(btn),
        .TIME_ALL(time_all), .ACTIVE_SLOT(active_slot), .DISP_TIME(disp_time),
        .EDIT_DIGIT(edit_digit), .BLANK_MASK(blank_mask), .CHANGED(changed)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, chg_cnt = 0;
    always @(negedge clk) if (changed) chg_cnt++;

    typedef struct {
        logic [4:0] b;
        int         hold;
        int         exp_t;
        logic [3:0] exp_edit;
        int         exp_act;
    } vec_t;
    vec_t vec [20];

    int ms [NS];
    int ma, md, c0;
    int wt [4] = '{1, 10, 60, 600};

    task automatic check(string nm, int act_v, int exp_v);
        tests++;
        if (act_v != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(logic [4:0] m, int hold);
        btn = m;
        tick(hold);
        btn = 5'd0;
        tick(6);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 5'd0;
        tick(3);
        rst = 1'b0;
        tick(3);
    endtask

    function automatic int slot(int k);
        return int'(time_all[k*TW +: TW]);
    endfunction

    // reference model of one accepted tap, by priority LEFT>RIGHT>UP>DOWN>CENTER
    task automatic model_tap(logic [4:0] m);
        if (m[2])      md = (md + 1) % 4;
        else if (m[3]) md = (md + 3) % 4;
        else if (m[1]) ms[ma] = (ms[ma] + wt[md]) % MAXT;
        else if (m[4]) ms[ma] = (ms[ma] - wt[md] + MAXT) % MAXT;
        else if (m[0]) begin ma = (ma + 1) % NS; md = 3; end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; btn = 5'd0;
        vec[0]  = '{5'h02, 4,  600,  4'b1000, 0};
        vec[1]  = '{5'h08, 4,  600,  4'b0100, 0};
        vec[2]  = '{5'h02, 4,  660,  4'b0100, 0};
        vec[3]  = '{5'h08, 4,  660,  4'b0010, 0};
        vec[4]  = '{5'h10, 4,  650,  4'b0010, 0};
        vec[5]  = '{5'h08, 4,  650,  4'b0001, 0};
        vec[6]  = '{5'h10, 4,  649,  4'b0001, 0};
        vec[7]  = '{5'h08, 4,  649,  4'b1000, 0};
        vec[8]  = '{5'h10, 4,  49,   4'b1000, 0};
        vec[9]  = '{5'h10, 4,  3049, 4'b1000, 0};
        vec[10] = '{5'h04, 4,  3049, 4'b0001, 0};
        vec[11] = '{5'h06, 4,  3049, 4'b0010, 0};
        vec[12] = '{5'h01, 50, 0,    4'b1000, 1};
        vec[13] = '{5'h02, 4,  600,  4'b1000, 1};
        vec[14] = '{5'h0C, 4,  600,  4'b0001, 1};
        vec[15] = '{5'h12, 4,  601,  4'b0001, 1};
        vec[16] = '{5'h11, 4,  600,  4'b0001, 1};
        vec[17] = '{5'h01, 4,  0,    4'b1000, 2};
        vec[18] = '{5'h01, 4,  0,    4'b1000, 3};
        vec[19] = '{5'h01, 4,  3049, 4'b1000, 0};

        tick(3);
        check("rst_time_all", (time_all == '0) ? 1 : 0, 1);
        check("rst_active", int'(active_slot), 0);
        check("rst_disp", int'(disp_time), 0);
        check("rst_edit", int'(edit_digit), 4'b1000);
        check("rst_blank", int'(blank_mask), 0);
        check("rst_changed", int'(changed), 0);
        rst = 1'b0;
        tick(2);

        // first press latency
        en = 1'b1;
        tick(3);
        c0 = chg_cnt;
        btn = 5'h02;
        tick(3);
        check("lat_slot_e3", slot(0), 600);
        check("lat_disp_e3", int'(disp_time), 0);
        check("lat_chg_e3", int'(changed), 0);
        tick(1);
        check("lat_disp_e4", int'(disp_time), 600);
        check("lat_chg_e4", int'(changed), 1);
        btn = 5'd0;
        tick(8);
        check("lat_chg_count", chg_cnt - c0, 1);

        // vector table
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tap(vec[i].b, vec[i].hold);
            check($sformatf("vec%0d_disp", i), int'(disp_time), vec[i].exp_t);
            check($sformatf("vec%0d_edit", i), int'(edit_digit), int'(vec[i].exp_edit));
            check($sformatf("vec%0d_act", i), int'(active_slot), vec[i].exp_act);
        end

        // wrap boundaries
        do_reset();
        tap(5'h04, 3);
        tap(5'h10, 3);
        check("wrap_dn_3599", slot(0), 3599);
        tap(5'h02, 3);
        check("wrap_up_0", slot(0), 0);
        tap(5'h04, 3); tap(5'h04, 3); tap(5'h04, 3);
        tap(5'h10, 3);
        check("wrap_dn_3000", slot(0), 3000);
        do_reset();
        tap(5'h04, 3);
        for (int i = 0; i < 5; i++) tap(5'h02, 3);
        tap(5'h04, 3);
        tap(5'h10, 3);
        check("wrap_dn_3595", slot(0), 3595);

        // hold-to-repeat
        do_reset();
        tap(5'h04, 3);
        c0 = chg_cnt;
        btn = 5'h02;
        tick(1000);
        btn = 5'd0;
        tick(10);
        check("rep_slot", slot(0), 1 + (1000 - 500) / 100);
        tick(300);
        check("rep_slot_after", slot(0), 6);
        check("rep_chg_count", chg_cnt - c0, 6);

        // CENTER short then long
        do_reset();
        tap(5'h01, 50);
        check("ctr_active", int'(active_slot), 1);
        check("ctr_disp", int'(disp_time), 0);
        tap(5'h08, 3);
        tap(5'h02, 3);
        tap(5'h02, 3);
        check("ctr_slot1_120", slot(1), 120);
        c0 = chg_cnt;
        tap(5'h01, 1200);
        check("clr_slot1", slot(1), 0);
        check("clr_active", int'(active_slot), 1);
        check("clr_chg", chg_cnt - c0, 1);

        // ENABLE low, then rising edge and blink
        en = 1'b0;
        tick(2);
        c0 = chg_cnt;
        tap(5'h02, 5);
        check("dis_slot1", slot(1), 0);
        check("dis_chg", chg_cnt - c0, 0);
        check("dis_blank", int'(blank_mask), 0);
        en = 1'b1;
        tick(250);
        check("en_edit", int'(edit_digit), 4'b1000);
        check("blink_vis", int'(blank_mask), 0);
        tick(500);
        check("blink_hid", int'(blank_mask), 4'b1000);

        // reset during repeat
        do_reset();
        tap(5'h04, 3);
        btn = 5'h02;
        tick(700);
        check("mid_rep_slot", slot(0), 3);
        rst = 1'b1;
        tick(3);
        check("mid_rst_slots", (time_all == '0) ? 1 : 0, 1);
        check("mid_rst_edit", int'(edit_digit), 4'b1000);
        rst = 1'b0;
        c0 = chg_cnt;
        tick(700);
        check("held_after_rst", slot(0), 0);
        check("held_after_rst_chg", chg_cnt - c0, 0);
        btn = 5'd0;
        tick(6);
        tap(5'h02, 3);
        check("repress_after_rst", slot(0), 600);

        // random taps vs. model
        do_reset();
        for (int k = 0; k < NS; k++) ms[k] = 0;
        ma = 0; md = 3;
        for (int i = 0; i < 60; i++) begin
            logic [4:0] m;
            m = 5'($urandom_range(1, 31));
            tap(m, int'($urandom_range(1, 8)));
            model_tap(m);
            for (int k = 0; k < NS; k++)
                check($sformatf("rnd%0d_slot%0d", i, k), slot(k), ms[k]);
            check($sformatf("rnd%0d_act", i), int'(active_slot), ma);
            check($sformatf("rnd%0d_edit", i), int'(edit_digit), 1 << md);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
